// File: rtl/vfilter_core_5x5.sv
// vfilter_core_5x5: streaming 5x5 neighbourhood generator for raster video.
//   Four line buffers hold the previous four lines. Five 5-deep column tap rows
//   form a 25-pixel window for every accepted pixel strobe. x1 is the oldest
//   pixel (c-4, r-4), xD is the centre and xP is the newest pixel (c, r).
//   With bypass=0, de_o marks windows whose pixels all lie inside the frame:
//   (W-4) x (H-4) per frame.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   bypass            1 = every strobe passes through, all window taps = pixel
//   di_i, de_i        pixel and pixel strobe
//   hs_i              1 = horizontal blanking
//   vs_i              1 = frame active, 0 = vertical blanking
//   x1..x9, xA..xP    window, row-major: x1-x5 (r-4) .. xL-xP (r)
//   de_o, hs_o, vs_o  window valid and sync signals, aligned to the window
//
// Build option
//   VFILTER_CORE_5X5_LB_REG_EN: registers line-buffer read data, so all
//   outputs have 2-clk latency instead of 1. The window contents do not change.
module vfilter_core_5x5 #(
    parameter int unsigned DE_I_PERIOD   = 0,
    parameter int unsigned LINE_SIZE_MAX = 4096,
    parameter int unsigned DATA_WIDTH    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  bypass,
    input  logic [DATA_WIDTH-1:0] di_i,
    input  logic                  de_i,
    input  logic                  hs_i,
    input  logic                  vs_i,
    output logic [DATA_WIDTH-1:0] x1,
    output logic [DATA_WIDTH-1:0] x2,
    output logic [DATA_WIDTH-1:0] x3,
    output logic [DATA_WIDTH-1:0] x4,
    output logic [DATA_WIDTH-1:0] x5,
    output logic [DATA_WIDTH-1:0] x6,
    output logic [DATA_WIDTH-1:0] x7,
    output logic [DATA_WIDTH-1:0] x8,
    output logic [DATA_WIDTH-1:0] x9,
    output logic [DATA_WIDTH-1:0] xA,
    output logic [DATA_WIDTH-1:0] xB,
    output logic [DATA_WIDTH-1:0] xC,
    output logic [DATA_WIDTH-1:0] xD,
    output logic [DATA_WIDTH-1:0] xE,
    output logic [DATA_WIDTH-1:0] xF,
    output logic [DATA_WIDTH-1:0] xG,
    output logic [DATA_WIDTH-1:0] xH,
    output logic [DATA_WIDTH-1:0] xI,
    output logic [DATA_WIDTH-1:0] xJ,
    output logic [DATA_WIDTH-1:0] xK,
    output logic [DATA_WIDTH-1:0] xL,
    output logic [DATA_WIDTH-1:0] xM,
    output logic [DATA_WIDTH-1:0] xN,
    output logic [DATA_WIDTH-1:0] xO,
    output logic [DATA_WIDTH-1:0] xP,
    output logic                  de_o,
    output logic                  hs_o,
    output logic                  vs_o
);

    localparam int unsigned AW = (LINE_SIZE_MAX > 1) ? $clog2(LINE_SIZE_MAX) : 1;
    localparam int unsigned CW = AW + 1;
    localparam int unsigned NT = 25;

    typedef logic [DATA_WIDTH-1:0] pix_t;

    // Raster position tracking
    logic [CW-1:0] col_cnt;
    logic [2:0]    row_cnt;     // saturates at 4: only "r >= 4" matters
    logic          hs_d;
    logic          line_de;
    logic          frame_ok;    // cleared by reset, set once vs_i is seen low

    logic          in_range;
    logic [AW-1:0] addr;
    logic          pix_ok;
    logic          gate_c;

    assign in_range = (col_cnt < CW'(LINE_SIZE_MAX));
    assign addr     = col_cnt[AW-1:0];
    assign pix_ok   = de_i && in_range;
    assign gate_c   = in_range && (col_cnt >= CW'(4)) && (row_cnt == 3'd4) && frame_ok;

    // Column and row counters
    always_ff @(posedge clk) begin
        if (rst) begin
            col_cnt  <= '0;
            row_cnt  <= '0;
            hs_d     <= 1'b1;
            line_de  <= 1'b0;
            frame_ok <= 1'b0;
        end else begin
            hs_d <= hs_i;
            if (hs_i)
                col_cnt <= '0;
            else if (pix_ok)
                col_cnt <= col_cnt + CW'(1);

            if (!vs_i) begin
                row_cnt  <= '0;
                line_de  <= 1'b0;
                frame_ok <= 1'b1;
            end else if (hs_i && !hs_d) begin
                if (line_de && (row_cnt != 3'd4))
                    row_cnt <= row_cnt + 3'd1;
                line_de <= 1'b0;
            end else if (de_i) begin
                line_de <= 1'b1;
            end
        end
    end

    // Line buffers: lb0 = line y-1 .. lb3 = line y-4
    pix_t lb0 [LINE_SIZE_MAX];
    pix_t lb1 [LINE_SIZE_MAX];
    pix_t lb2 [LINE_SIZE_MAX];
    pix_t lb3 [LINE_SIZE_MAX];
    pix_t rd  [4];

    // Window-stage view of the strobe (direct or one stage delayed)
    logic          s_de;
    logic          s_ok;
    logic          s_gate;
    logic          s_byp;
    logic          s_hs;
    logic          s_vs;
    pix_t          s_di;
    logic [AW-1:0] s_addr;

`ifdef VFILTER_CORE_5X5_LB_REG_EN
    // Read-before-write forwarding, needed only when strobes can be adjacent
    localparam bit RD_FWD = (DE_I_PERIOD == 0);

    logic fwd_hit;
    assign fwd_hit = RD_FWD && s_de && s_ok && (s_addr == addr);

    // Registered read data: a write still in flight to the same address wins
    always_ff @(posedge clk) begin
        if (pix_ok) begin
            rd[0] <= lb0[addr];
            rd[1] <= fwd_hit ? rd[0] : lb1[addr];
            rd[2] <= fwd_hit ? rd[1] : lb2[addr];
            rd[3] <= fwd_hit ? rd[2] : lb3[addr];
        end
    end

    // Strobe pipeline aligned to the registered read data
    always_ff @(posedge clk) begin
        if (rst) begin
            s_de   <= 1'b0;
            s_ok   <= 1'b0;
            s_gate <= 1'b0;
            s_byp  <= 1'b0;
            s_hs   <= 1'b1;
            s_vs   <= 1'b0;
            s_di   <= '0;
            s_addr <= '0;
        end else begin
            s_de   <= de_i;
            s_ok   <= in_range;
            s_gate <= gate_c;
            s_byp  <= bypass;
            s_hs   <= hs_i;
            s_vs   <= vs_i;
            s_di   <= di_i;
            s_addr <= addr;
        end
    end
`else
    // Asynchronous read: same-edge writes see the old contents
    always_comb begin
        rd[0] = lb0[addr];
        rd[1] = lb1[addr];
        rd[2] = lb2[addr];
        rd[3] = lb3[addr];
    end

    assign s_de   = de_i;
    assign s_ok   = in_range;
    assign s_gate = gate_c;
    assign s_byp  = bypass;
    assign s_hs   = hs_i;
    assign s_vs   = vs_i;
    assign s_di   = di_i;
    assign s_addr = addr;
`endif

    // Each line moves one buffer deeper; lb0 takes the new pixel
    always_ff @(posedge clk) begin
        if (pix_ok)
            lb0[addr] <= di_i;
        if (s_de && s_ok) begin
            lb1[s_addr] <= rd[0];
            lb2[s_addr] <= rd[1];
            lb3[s_addr] <= rd[2];
        end
    end

    // Column taps: row 0 is line y-4, row 4 is the current line
    pix_t tap [5][5];
    pix_t nxt [5][5];
    pix_t win [NT];

    always_comb begin
        for (int k = 0; k < 5; k++) begin
            for (int j = 0; j < 4; j++)
                nxt[k][j] = tap[k][j+1];
            nxt[k][4] = (k == 4) ? s_di : rd[3-k];
        end
    end

    // Window and sync output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 5; k++)
                for (int j = 0; j < 5; j++)
                    tap[k][j] <= '0;
            for (int i = 0; i < NT; i++)
                win[i] <= '0;
            de_o <= 1'b0;
            hs_o <= 1'b1;
            vs_o <= 1'b0;
        end else begin
            hs_o <= s_hs;
            vs_o <= s_vs;
            de_o <= s_de && (s_byp || s_gate);
            if (s_de && s_ok)
                for (int k = 0; k < 5; k++)
                    for (int j = 0; j < 5; j++)
                        tap[k][j] <= nxt[k][j];
            if (s_de && (s_ok || s_byp))
                for (int k = 0; k < 5; k++)
                    for (int j = 0; j < 5; j++)
                        win[k*5+j] <= s_byp ? s_di : nxt[k][j];
        end
    end

    assign x1 = win[0];
    assign x2 = win[1];
    assign x3 = win[2];
    assign x4 = win[3];
    assign x5 = win[4];
    assign x6 = win[5];
    assign x7 = win[6];
    assign x8 = win[7];
    assign x9 = win[8];
    assign xA = win[9];
    assign xB = win[10];
    assign xC = win[11];
    assign xD = win[12];
    assign xE = win[13];
    assign xF = win[14];
    assign xG = win[15];
    assign xH = win[16];
    assign xI = win[17];
    assign xJ = win[18];
    assign xK = win[19];
    assign xL = win[20];
    assign xM = win[21];
    assign xN = win[22];
    assign xO = win[23];
    assign xP = win[24];

endmodule

// File: tb/tb_vfilter_core_5x5.sv
// Directed bench for vfilter_core_5x5: raster frames with known pixel values;
// the window, sync outputs and pulse counts are compared every cycle.
module tb_vfilter_core_5x5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, bypass, de_i, hs_i, vs_i;
    logic [7:0] di_i;
    logic [7:0] x1, x2, x3, x4, x5, x6, x7, x8, x9, xA, xB, xC, xD;
    logic [7:0] xE, xF, xG, xH, xI, xJ, xK, xL, xM, xN, xO, xP;
    logic       de_o, hs_o, vs_o;

    vfilter_core_5x5 #(
        .DE_I_PERIOD   (0),
        .LINE_SIZE_MAX (64),
        .DATA_WIDTH    (8)
    ) dut (
        .clk (clk), .rst (rst), .bypass (bypass),
        .di_i (di_i), .de_i (de_i), .hs_i (hs_i), .vs_i (vs_i),
        .x1 (x1), .x2 (x2), .x3 (x3), .x4 (x4), .x5 (x5),
        .x6 (x6), .x7 (x7), .x8 (x8), .x9 (x9), .xA (xA),
        .xB (xB), .xC (xC), .xD (xD), .xE (xE), .xF (xF),
        .xG (xG), .xH (xH), .xI (xI), .xJ (xJ), .xK (xK),
        .xL (xL), .xM (xM), .xN (xN), .xO (xO), .xP (xP),
        .de_o (de_o), .hs_o (hs_o), .vs_o (vs_o)
    );

    logic [199:0] got_win;
    assign got_win = {xP, xO, xN, xM, xL, xK, xJ, xI, xH, xG, xF, xE, xD,
                      xC, xB, xA, x9, x8, x7, x6, x5, x4, x3, x2, x1};

    int n_chk = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [199:0] got, input logic [199:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Expectation for the cycle being driven, then aligned to DUT latency
    logic         exp_en = 1'b0, exp_de = 1'b0, exp_hs = 1'b1, exp_vs = 1'b0, exp_wv = 1'b0;
    logic [199:0] exp_win = '0;
    logic         c1_en = 1'b0, c1_de, c1_hs, c1_vs, c1_wv;
    logic [199:0] c1_win;
    logic         f_en, f_de, f_hs, f_vs, f_wv;
    logic [199:0] f_win;

    always @(posedge clk) begin
        if (rst) begin
            c1_en <= 1'b1; c1_de <= 1'b0; c1_hs <= 1'b1; c1_vs <= 1'b0;
            c1_wv <= 1'b1; c1_win <= '0;
        end else begin
            c1_en <= exp_en; c1_de <= exp_de; c1_hs <= exp_hs; c1_vs <= exp_vs;
            c1_wv <= exp_wv; c1_win <= exp_win;
        end
    end

`ifdef VFILTER_CORE_5X5_LB_REG_EN
    logic         c2_en = 1'b0, c2_de, c2_hs, c2_vs, c2_wv;
    logic [199:0] c2_win;
    always @(posedge clk) begin
        if (rst) begin
            c2_en <= 1'b1; c2_de <= 1'b0; c2_hs <= 1'b1; c2_vs <= 1'b0;
            c2_wv <= 1'b1; c2_win <= '0;
        end else begin
            c2_en <= c1_en; c2_de <= c1_de; c2_hs <= c1_hs; c2_vs <= c1_vs;
            c2_wv <= c1_wv; c2_win <= c1_win;
        end
    end
    always_comb begin
        f_en = c2_en; f_de = c2_de; f_hs = c2_hs; f_vs = c2_vs; f_wv = c2_wv; f_win = c2_win;
    end
`else
    always_comb begin
        f_en = c1_en; f_de = c1_de; f_hs = c1_hs; f_vs = c1_vs; f_wv = c1_wv; f_win = c1_win;
    end
`endif

    int obs_cnt = 0;

    always @(negedge clk) begin
        if (f_en) begin
            check_eq("ctl{de,hs,vs}", 200'({de_o, hs_o, vs_o}), 200'({f_de, f_hs, f_vs}));
            if (f_wv)
                check_eq("window", got_win, f_win);
            if (de_o === 1'b1)
                obs_cnt++;
        end
    end

    function automatic logic [199:0] win_of(input int c, input int r, input int mode, input bit byp);
        logic [199:0] w;
        int v;
        w = '0;
        for (int k = 0; k < 5; k++)
            for (int j = 0; j < 5; j++) begin
                if (byp)
                    v = (mode == 0) ? c : r;
                else
                    v = (mode == 0) ? (c - 4 + j) : (r - 4 + k);
                w[(k*5+j)*8 +: 8] = 8'(v);
            end
        return w;
    endfunction

    // One input cycle; caller may refine the strobe expectation afterwards
    task automatic step(input logic r_, input logic d_, input logic h_, input logic v_, input logic [7:0] px);
        @(posedge clk);
        #1;
        rst = r_; de_i = d_; hs_i = h_; vs_i = v_; di_i = px;
        exp_en = 1'b1; exp_de = 1'b0; exp_hs = h_; exp_vs = v_;
        if (r_) begin
            exp_hs = 1'b1; exp_vs = 1'b0; exp_wv = 1'b1; exp_win = '0;
        end
    endtask

    bit tb_fok = 1'b0;

    // mode 0: pixel = column index, mode 1: pixel = row index
    task automatic run_frame(input string tag, input int w, input int h, input int mode,
                             input int gap, input bit byp, input int rst_line, input int want);
        bit v;
        logic [7:0] px;
        obs_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
            bypass = byp;
        end
        tb_fok = 1'b1;
        for (int r = 0; r < h; r++) begin
            for (int i = 0; i < 3; i++) begin
                if (r == rst_line && i == 0) begin
                    step(1'b1, 1'b0, 1'b1, 1'b1, 8'd0);
                    tb_fok = 1'b0;
                end else begin
                    step(1'b0, 1'b0, 1'b1, 1'b1, 8'd0);
                end
            end
            for (int c = 0; c < w; c++) begin
                px = 8'((mode == 0) ? c : r);
                step(1'b0, 1'b1, 1'b0, 1'b1, px);
                v = byp || (tb_fok && c >= 4 && r >= 4);
                exp_de = v;
                exp_wv = v;
                if (v)
                    exp_win = win_of(c, r, mode, byp);
                for (int g = 0; g < gap; g++)
                    step(1'b0, 1'b0, 1'b0, 1'b1, 8'd0);
            end
        end
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b0, 1'b1, 1'b1, 8'd0);
        check_eq(tag, 200'(obs_cnt), 200'(want));
    endtask

    initial begin
        rst = 1'b1; bypass = 1'b0; de_i = 1'b0; hs_i = 1'b1; vs_i = 1'b0; di_i = 8'd0;
        repeat (3) step(1'b1, 1'b0, 1'b1, 1'b0, 8'd0);

        run_frame("cnt col f0",    24, 24, 0, 0, 1'b0, -1, 400);
        run_frame("cnt col f1",    24, 24, 0, 0, 1'b0, -1, 400);
        run_frame("cnt gap2",      24, 24, 0, 2, 1'b0, -1, 400);
        run_frame("cnt gap4",      24, 24, 0, 4, 1'b0, -1, 400);
        run_frame("cnt row",       24, 24, 1, 0, 1'b0, -1, 400);
        run_frame("cnt bypass",    24, 24, 0, 0, 1'b1, -1, 576);
        run_frame("cnt rst f0",    24, 24, 0, 0, 1'b0, 10, 120);
        run_frame("cnt rst f1",    24, 24, 0, 0, 1'b0, -1, 400);
        run_frame("cnt narrow",     4, 24, 0, 0, 1'b0, -1, 0);
        run_frame("cnt short",     24,  4, 0, 0, 1'b0, -1, 0);
        run_frame("cnt col again", 24, 24, 0, 1, 1'b0, -1, 400);

        repeat (4) step(1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
